// File: rtl/alu_pkg.sv
// Shared ALU definitions for the shift path.
// Used by the left/right shifters and the ALU top.
package alu_pkg;

  localparam int ALU_W   = 6;
  localparam int SHAMT_W = 3;

  localparam logic SHL_LOGIC = 1'b0;
  localparam logic SHL_ROT   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shl_state_e;

endpackage

// File: rtl/alu_shl_seq_6bit_if.sv
// Start/busy/done handshake between the ALU
// sequencer (master) and the left shifter (slave).
interface alu_shl_seq_6bit_if;
  import alu_pkg::*;

  logic               start;
  logic [ALU_W-1:0]   in;
  logic [SHAMT_W-1:0] shift;
  logic               rotate;
  logic [ALU_W-1:0]   out;
  logic               carry;
  logic               busy;
  logic               done;

  modport master (
    output start, in, shift, rotate,
    input  out, carry, busy, done
  );

  modport slave (
    input  start, in, shift, rotate,
    output out, carry, busy, done
  );

endinterface

// File: rtl/alu_shl_step.sv
// One combinational left-shift step: logical
// (zero fill) or rotate, plus the bit pushed out.
module alu_shl_step
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] data,
  input  logic         mode,
  output logic [W-1:0] nxt,
  output logic         carry
);

  logic fill;

  assign fill  = (mode == SHL_ROT) ? data[W-1] : 1'b0;
  assign nxt   = {data[W-2:0], fill};
  assign carry = data[W-1];

endmodule

// File: rtl/alu_shl_seq_6bit.sv
// Sequential 6-bit left shifter/rotator, one bit
// per clock, with start/busy/done handshake.
module alu_shl_seq_6bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_shl_seq_6bit_if.slave  bus
);

  shl_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             mode;
  logic [WIDTH-1:0] data;
  logic             cry;
  logic [WIDTH-1:0] step_nxt;
  logic             step_c;

  alu_shl_step #(.W(WIDTH)) u_step (
    .data  (data),
    .mode  (mode),
    .nxt   (step_nxt),
    .carry (step_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      mode  <= SHL_LOGIC;
      data  <= '0;
      cry   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.start) begin
            data  <= bus.in;
            cnt   <= bus.shift;
            mode  <= bus.rotate;
            cry   <= 1'b0;
            state <= (bus.shift == '0) ? DONE
                                       : SHIFT;
          end
        end
        (state == SHIFT): begin
          data <= step_nxt;
          cry  <= step_c;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= DONE;
        end
        (state == DONE): begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.out   = data;
  assign bus.carry = cry;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);

endmodule

// File: tb/tb_alu_shl_seq_6bit.sv
// Scoreboard bench for alu_shl_seq_6bit: directed
// vectors push expectations, a monitor checks on done.
module tb_alu_shl_seq_6bit;

  typedef struct {
    logic [5:0] o;
    logic       c;
    int         dcyc;
    int         blen;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   busy_cnt;
  logic prev_done;
  exp_t sb[$];

  alu_shl_seq_6bit_if bus();

  alu_shl_seq_6bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (prev_done && bus.done)
        chk("done_pulse_width", 32'd2, 32'd1);
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out", 32'(bus.out), 32'(e.o));
          chk("carry", 32'(bus.carry), 32'(e.c));
          chk("done_cycle", cyc, e.dcyc);
          chk("busy_len", busy_cnt, e.blen);
        end
        busy_cnt = 0;
      end
      prev_done = bus.done;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.done) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [5:0] a,
                       input logic [2:0] s,
                       input logic       r,
                       input logic [5:0] eo,
                       input logic       ec);
    exp_t e;
    wait_idle();
    bus.start  = 1'b1;
    bus.in     = a;
    bus.shift  = s;
    bus.rotate = r;
    e.o    = eo;
    e.c    = ec;
    e.dcyc = cyc + 1 + int'(s);
    e.blen = int'(s) + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.in     = 6'($urandom);
    bus.shift  = 3'($urandom);
    bus.rotate = 1'($urandom);
  endtask

  initial begin
    int n;
    checks     = 0;
    errors     = 0;
    busy_cnt   = 0;
    prev_done  = 1'b0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.in     = '0;
    bus.shift  = '0;
    bus.rotate = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(bus.out), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(6'b000111, 3'd3, 1'b0, 6'b111000, 1'b0);
    issue(6'b101001, 3'd2, 1'b1, 6'b100110, 1'b0);
    issue(6'b111111, 3'd7, 1'b0, 6'b000000, 1'b0);
    issue(6'b100000, 3'd7, 1'b1, 6'b000001, 1'b1);
    issue(6'b110101, 3'd0, 1'b0, 6'b110101, 1'b0);
    issue(6'b010011, 3'd6, 1'b0, 6'b000000, 1'b1);
    issue(6'b101101, 3'd6, 1'b1, 6'b101101, 1'b1);
    issue(6'b100001, 3'd1, 1'b0, 6'b000010, 1'b1);

    // start pulses mid-shift and in the DONE cycle
    issue(6'b000011, 3'd5, 1'b0, 6'b100000, 1'b1);
    bus.start = 1'b1;
    bus.in    = 6'b000001;
    bus.shift = 3'd1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("done_timeout", 32'd1, 32'd0);
    bus.start = 1'b1;
    bus.in    = 6'b000001;
    bus.shift = 3'd0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_out", 32'(bus.out), 32'b100000);
    chk("ignored_starts", sb.size(), 0);

    issue(6'b010101, 3'd4, 1'b0, 6'b000000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out", 32'(bus.out), 32'd0);
    chk("abort_carry", 32'(bus.carry), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(6'b000001, 3'd1, 1'b0, 6'b000010, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("drain_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    chk("final_out", 32'(bus.out), 32'b000010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
